chan_select: RTL and testbench

Per-channel selector placed directly downstream of `exp_shifter`. It takes the gain-corrected FFT frames, one sample per bin, and drops the bins that are disabled in a double-buffered channel mask. It forwards only the enabled bins and regenerates `tlast` so that it marks the last *kept* bin of each frame. The result is a compacted frame stream for the RFNoC output side, with EOB carried through.

---
 rtl/chan_select.sv | 145 ++++++++++++++
 tb/tb_chan_select.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_select.sv
// chan_select: per-bin selector downstream of exp_shifter.
// Drops FFT bins that are disabled in a double-buffered channel mask and
// regenerates tlast so that it marks the last kept bin of each frame.
// A one-entry hold register (H) delays every kept bin until the next kept
// bin, or the end of the frame, shows whether it is the last kept one.
// Optional feature: define CHAN_SELECT_STATS_EN to enable the frame_cnt
// counter; otherwise frame_cnt is tied to zero.
module chan_select #(
    parameter int MAX_BINS = 512
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic [9:0]  fft_size,
    input  logic        mask_wr_en,
    input  logic [8:0]  mask_wr_addr,
    input  logic        mask_wr_data,
    input  logic [31:0] s_axis_tdata,
    input  logic [23:0] s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic [23:0] m_axis_tuser,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        eob_tag,
    output logic [15:0] frame_cnt
);

    logic [MAX_BINS-1:0] shadow_mask;
    logic [MAX_BINS-1:0] active_mask;
    logic [MAX_BINS-1:0] shadow_next;

    logic        h_valid;
    logic        h_final;
    logic [31:0] h_data;
    logic [23:0] h_user;

    logic [8:0]  bin;
    logic        keep;
    logic        o_free;
    logic        accept;
    logic        flush;

    assign bin    = s_axis_tuser[8:0];
    assign keep   = active_mask[bin] & ({1'b0, bin} < fft_size);
    assign o_free = !m_axis_tvalid | m_axis_tready;
    assign flush  = h_valid & h_final & o_free;

    assign s_axis_tready = o_free & !(h_valid & h_final);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign eob_tag       = m_axis_tuser[23];

    // Shadow bank including this cycle's write, so a write in the tlast
    // cycle is still picked up by the bank copy.
    always_comb begin
        shadow_next = shadow_mask;
        if (mask_wr_en) begin
            shadow_next[mask_wr_addr] = mask_wr_data;
        end
    end

    // Mask banks: shadow takes writes, active is refreshed at each frame end.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            shadow_mask <= '1;
            active_mask <= '1;
        end else begin
            shadow_mask <= shadow_next;
            if (accept && s_axis_tlast) begin
                active_mask <= shadow_next;
            end
        end
    end

    // Hold and output registers: compaction and tlast regeneration.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            h_valid       <= 1'b0;
            h_final       <= 1'b0;
            h_data        <= '0;
            h_user        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            if (o_free) begin
                m_axis_tvalid <= 1'b0;
            end
            // flush and accept are exclusive: a final held bin blocks input
            if (flush) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= h_data;
                m_axis_tuser  <= h_user;
                m_axis_tlast  <= 1'b1;
                h_valid       <= 1'b0;
                h_final       <= 1'b0;
            end else if (accept) begin
                if (keep) begin
                    if (h_valid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= h_data;
                        m_axis_tuser  <= h_user;
                        m_axis_tlast  <= 1'b0;
                    end
                    h_valid <= 1'b1;
                    h_final <= s_axis_tlast;
                    h_data  <= s_axis_tdata;
                    h_user  <= s_axis_tuser;
                end else if (s_axis_tlast) begin
                    // Dropped final bin: the held bin closes the frame and
                    // inherits the dropped bin's EOB flag.
                    if (h_valid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= h_data;
                        m_axis_tuser  <= {h_user[23] | s_axis_tuser[23], h_user[22:0]};
                        m_axis_tlast  <= 1'b1;
                    end
                    h_valid <= 1'b0;
                    h_final <= 1'b0;
                end
            end
        end
    end

`ifdef CHAN_SELECT_STATS_EN
    logic [15:0] frame_cnt_q;

    // Count frames completed on the output handshake; wraps naturally.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            frame_cnt_q <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_select.sv
// Self-checking bench for chan_select: a reference model pushes expected
// output beats as input beats are accepted; a monitor pops and compares.
module tb_chan_select;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [9:0]  fft_size;
    logic        mask_wr_en;
    logic [8:0]  mask_wr_addr;
    logic        mask_wr_data;
    logic [31:0] s_data;
    logic [23:0] s_user;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [31:0] m_data;
    logic [23:0] m_user;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        eob_tag;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    chan_select dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .fft_size      (fft_size),
        .mask_wr_en    (mask_wr_en),
        .mask_wr_addr  (mask_wr_addr),
        .mask_wr_data  (mask_wr_data),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .eob_tag       (eob_tag),
        .frame_cnt     (frame_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [23:0] user;
        logic        last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      pend;
    beat_t      mon_e;
    bit         have_pend;
    bit [511:0] mdl_shadow;
    bit [511:0] mdl_active;
    int         exp_frames;
    int         frame_id;
    int         total;
    int         bad;
    int         cyc;
    int         acc_cyc;
    int         last_out_cyc;
    logic [8:0] last_out_bin;
    logic       last_out_eob;
    int         out_beats;
    int         waits;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] exp_fcnt();
`ifdef CHAN_SELECT_STATS_EN
        return 16'(exp_frames);
`else
        return 16'd0;
`endif
    endfunction

    // Monitor: every output handshake is compared against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (!sync_reset && m_valid && m_ready) begin
            out_beats++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat got data=%h user=%h last=%b, queue empty", m_data, m_user, m_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_data !== mon_e.data || m_user !== mon_e.user || m_last !== mon_e.last || eob_tag !== mon_e.user[23]) begin
                    bad++;
                    $display("FAIL out_beat got data=%h user=%h last=%b eob=%b want data=%h user=%h last=%b eob=%b",
                             m_data, m_user, m_last, eob_tag, mon_e.data, mon_e.user, mon_e.last, mon_e.user[23]);
                end
                if (mon_e.last) begin
                    exp_frames++;
                    last_out_cyc = cyc;
                    last_out_bin = mon_e.user[8:0];
                    last_out_eob = mon_e.user[23];
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        have_pend  = 0;
        mdl_shadow = '1;
        mdl_active = '1;
        exp_frames = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [23:0] u, input logic last);
        bit kept;
        kept = mdl_active[u[8:0]] && ({1'b0, u[8:0]} < fft_size);
        if (kept) begin
            if (have_pend) begin
                pend.last = 0;
                exp_q.push_back(pend);
            end
            pend.data = d;
            pend.user = u;
            have_pend = 1;
            if (last) begin
                pend.last = 1;
                exp_q.push_back(pend);
                have_pend = 0;
            end
        end else if (last && have_pend) begin
            pend.user[23] = pend.user[23] | u[23];
            pend.last = 1;
            exp_q.push_back(pend);
            have_pend = 0;
        end
        if (last) mdl_active = mdl_shadow;
    endtask

    // Entered and left at a falling edge.
    task automatic send_beat(input logic [8:0] b, input logic last, input logic eob,
                             input logic wr = 1'b0, input logic [8:0] waddr = 9'd0, input logic wdata = 1'b0);
        int budget;
        logic [31:0] d;
        logic [23:0] u;
        budget = 0;
        d = {frame_id[15:0], 7'h00, b};
        u = {eob, frame_id[13:0], b};
        s_data = d;
        s_user = u;
        s_last = last;
        s_valid = 1'b1;
        mask_wr_en = wr;
        mask_wr_addr = waddr;
        mask_wr_data = wdata;
        #1;
        while (!s_ready && budget < 40) begin
            @(negedge clk);
            #1;
            budget++;
            waits++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout bin=%0d s_ready=%b want 1", b, s_ready);
        end else begin
            acc_cyc = cyc;
            @(posedge clk);
            if (wr) mdl_shadow[waddr] = wdata;
            model_accept(d, u, last);
        end
        @(negedge clk);
        s_valid = 1'b0;
        mask_wr_en = 1'b0;
    endtask

    task automatic send_frame(input logic eob);
        for (int b = 0; b < 8; b++) send_beat(9'(b), b == 7, eob && (b == 7));
        frame_id++;
    endtask

    task automatic write_mask(input logic [8:0] a, input logic v);
        mask_wr_en = 1'b1;
        mask_wr_addr = a;
        mask_wr_data = v;
        @(posedge clk);
        mdl_shadow[a] = v;
        @(negedge clk);
        mask_wr_en = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while ((exp_q.size() != 0 || m_valid) && b < 60);
        total++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain left=%0d m_valid=%b want 0 and 0", exp_q.size(), m_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        sync_reset = 1'b1;
        repeat (3) @(negedge clk);
        sync_reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got valid=%b last=%b want 0 0", m_valid, m_last);
        end
        total++;
        if (m_data !== 32'd0 || m_user !== 24'd0 || eob_tag !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got data=%h user=%h eob=%b want 0", m_data, m_user, eob_tag);
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b want 1", s_ready);
        end
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_fcnt got %0d want 0", frame_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_pass_through();
        out_beats = 0;
        send_frame(1'b0);
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL pt_bubble got s_ready=%b want 0", s_ready);
        end
        drain();
        total++;
        if (out_beats != 8 || last_out_bin !== 9'd7) begin
            bad++;
            $display("FAIL pt_count got beats=%0d last_bin=%0d want 8 7", out_beats, last_out_bin);
        end
        total++;
        if (last_out_cyc - acc_cyc != 2) begin
            bad++;
            $display("FAIL pt_latency got %0d want 2", last_out_cyc - acc_cyc);
        end
    endtask

    task automatic test_sparse();
        for (int b = 0; b < 8; b++) write_mask(9'(b), (b == 1) || (b == 3));
        send_frame(1'b0);
        drain();
        out_beats = 0;
        send_frame(1'b0);
        drain();
        total++;
        if (out_beats != 2 || last_out_bin !== 9'd3) begin
            bad++;
            $display("FAIL sparse_count got beats=%0d last_bin=%0d want 2 3", out_beats, last_out_bin);
        end
        total++;
        if (last_out_cyc - acc_cyc != 1) begin
            bad++;
            $display("FAIL sparse_latency got %0d want 1", last_out_cyc - acc_cyc);
        end
    endtask

    task automatic test_all_disabled();
        write_mask(9'd1, 1'b0);
        write_mask(9'd3, 1'b0);
        send_frame(1'b0);
        drain();
        out_beats = 0;
        waits = 0;
        send_frame(1'b0);
        drain();
        total++;
        if (out_beats != 0 || waits != 0) begin
            bad++;
            $display("FAIL empty_frame got beats=%0d stalls=%0d want 0 0", out_beats, waits);
        end
        total++;
        if (frame_cnt !== exp_fcnt()) begin
            bad++;
            $display("FAIL empty_fcnt got %0d want %0d", frame_cnt, exp_fcnt());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        for (int b = 0; b < 8; b++) write_mask(9'(b), 1'b1);
        send_frame(1'b0);
        drain();
        out_beats = 0;
        fork
            send_frame(1'b0);
            begin
                repeat (4) @(negedge clk);
                m_ready = 1'b0;
                #1;
                held = m_data;
                total++;
                if (m_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_valid got %b want 1", m_valid);
                end
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    total++;
                    if (m_data !== held || m_valid !== 1'b1 || s_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL bp_hold got data=%h valid=%b s_ready=%b want data=%h valid=1 s_ready=0",
                                 m_data, m_valid, s_ready, held);
                    end
                end
                @(negedge clk);
                m_ready = 1'b1;
            end
        join
        drain();
        total++;
        if (out_beats != 8) begin
            bad++;
            $display("FAIL bp_count got %0d want 8", out_beats);
        end
    endtask

    task automatic test_mid_frame_write();
        out_beats = 0;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) send_beat(9'(b), 1'b0, 1'b0, 1'b1, 9'd2, 1'b0);
            else if (b == 7) send_beat(9'(b), 1'b1, 1'b0, 1'b1, 9'd6, 1'b0);
            else send_beat(9'(b), 1'b0, 1'b0);
        end
        frame_id++;
        drain();
        total++;
        if (out_beats != 8) begin
            bad++;
            $display("FAIL midwr_cur got %0d want 8", out_beats);
        end
        out_beats = 0;
        send_frame(1'b0);
        drain();
        total++;
        if (out_beats != 6) begin
            bad++;
            $display("FAIL midwr_next got %0d want 6", out_beats);
        end
    endtask

    task automatic test_eob();
        write_mask(9'd7, 1'b0);
        send_frame(1'b0);
        drain();
        send_frame(1'b1);
        drain();
        total++;
        if (last_out_bin !== 9'd5 || last_out_eob !== 1'b1) begin
            bad++;
            $display("FAIL eob_last got bin=%0d eob=%b want 5 1", last_out_bin, last_out_eob);
        end
        total++;
        if (frame_cnt !== exp_fcnt()) begin
            bad++;
            $display("FAIL eob_fcnt got %0d want %0d", frame_cnt, exp_fcnt());
        end
    endtask

    task automatic test_fft_size();
        fft_size = 10'd5;
        out_beats = 0;
        send_frame(1'b0);
        drain();
        total++;
        if (out_beats != 4 || last_out_bin !== 9'd4) begin
            bad++;
            $display("FAIL fft_bound got beats=%0d last_bin=%0d want 4 4", out_beats, last_out_bin);
        end
        fft_size = 10'd8;
    endtask

    task automatic test_reset_mid_frame();
        for (int b = 0; b < 4; b++) send_beat(9'(b), 1'b0, 1'b0);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid got valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
        @(negedge clk);
        out_beats = 0;
        frame_id++;
        send_frame(1'b0);
        drain();
        total++;
        if (out_beats != 8 || frame_cnt !== exp_fcnt()) begin
            bad++;
            $display("FAIL rst_next got beats=%0d fcnt=%0d want 8 %0d", out_beats, frame_cnt, exp_fcnt());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        frame_id = 1;
        out_beats = 0;
        waits = 0;
        sync_reset = 1'b1;
        fft_size = 10'd8;
        mask_wr_en = 1'b0;
        mask_wr_addr = 9'd0;
        mask_wr_data = 1'b0;
        s_data = 32'd0;
        s_user = 24'd0;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        model_reset();
        test_reset();
        test_pass_through();
        test_sparse();
        test_all_disabled();
        test_backpressure();
        test_mid_frame_write();
        test_eob();
        test_fft_size();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
